keypad_scan: RTL

- Input-side counterpart of the multiplexed 7-segment display scanner: scans a 4x4 active-low key matrix, debounces it, and reports hex key codes.
- Shifts each accepted digit into a 16-bit entry register, which feeds the CPU's address/debug inputs at top level.
- Runs from the board clock alongside the display scanner.

---
 rtl/keypad_scan.sv | 116 +++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// 4x4 active-low key matrix scanner with frame-level debounce, one-shot press
// reporting and a 16-bit hex entry shift register.
module keypad_scan #(
  parameter int SCAN_DIV     = 4096,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic [3:0]  row,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] entry
);

  localparam int             CW   = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0]     DB   = 4'(DEBOUNCE_CNT);

  typedef enum logic {RELEASED, HELD} state_t;

  state_t        state;
  logic [CW-1:0] slot_cnt;
  logic [1:0]    row_idx;
  logic [3:0]    col_m, col_s;
  logic          hit_vld;
  logic [3:0]    hit_code;
  logic          cand_vld, cand_pressed;
  logic [3:0]    cand_code, stable_cnt;

  logic          slot_end, frame_end, col_hit, res_pressed, same;
  logic [1:0]    col_idx;
  logic [3:0]    res_code, nxt_cnt;

  assign row       = ~(4'b0001 << row_idx);
  assign slot_end  = (slot_cnt == LAST);
  assign frame_end = slot_end && (row_idx == 2'd3);
  assign col_hit   = (col_s != 4'hF);

  always_comb begin
    col_idx = '0;
    for (int i = 3; i >= 0; i--)
      if (!col_s[i]) col_idx = 2'(i);
  end

  // Earlier rows already recorded in the frame take priority over the row
  // being sampled now, giving lowest-index-wins across the whole matrix.
  always_comb begin
    res_pressed = hit_vld | col_hit;
    res_code    = 4'd0;
    if (hit_vld)      res_code = hit_code;
    else if (col_hit) res_code = {row_idx, col_idx};
    same    = cand_vld && (cand_pressed == res_pressed) && (cand_code == res_code);
    nxt_cnt = !same ? 4'd1 : (stable_cnt >= DB) ? DB : stable_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RELEASED;
      slot_cnt     <= '0;
      row_idx      <= '0;
      col_m        <= 4'hF;
      col_s        <= 4'hF;
      hit_vld      <= 1'b0;
      hit_code     <= '0;
      cand_vld     <= 1'b0;
      cand_pressed <= 1'b0;
      cand_code    <= '0;
      stable_cnt   <= '0;
      key_code     <= '0;
      key_valid    <= 1'b0;
      key_held     <= 1'b0;
      entry        <= '0;
    end else begin
      col_m     <= col;
      col_s     <= col_m;
      key_valid <= 1'b0;
      if (slot_end) begin
        slot_cnt <= '0;
        row_idx  <= row_idx + 2'd1;
        if (frame_end) begin
          hit_vld      <= 1'b0;
          hit_code     <= '0;
          // the new candidate always equals this frame's result
          cand_vld     <= 1'b1;
          cand_pressed <= res_pressed;
          cand_code    <= res_code;
          stable_cnt   <= nxt_cnt;
          case (state)
            RELEASED: if (res_pressed && nxt_cnt == DB) begin
              state     <= HELD;
              key_code  <= res_code;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              entry     <= {entry[11:0], res_code};
            end
            HELD: if (!res_pressed && nxt_cnt == DB) begin
              state    <= RELEASED;
              key_held <= 1'b0;
            end
            default: state <= RELEASED;
          endcase
        end else if (!hit_vld && col_hit) begin
          hit_vld  <= 1'b1;
          hit_code <= {row_idx, col_idx};
        end
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (clr) entry <= '0;
    end
  end

endmodule
